// File: rtl/axis_reshaper_pkg.sv
// Shared types and constants for the AXI-Stream reshaper controller.
// The lock FSM encoding and the minimum legal geometry live here.
package axis_reshaper_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    localparam int unsigned MIN_WIDTH  = 32'd2;
    localparam int unsigned MIN_HEIGHT = 32'd1;

    function automatic logic geom_ok(input int unsigned width, input int unsigned height);
        return (width >= MIN_WIDTH) && (height >= MIN_HEIGHT);
    endfunction

endpackage

// File: rtl/axis_reshaper_ctl_if.sv
// Snoop view of the reshaper input handshake (tvalid/tready/tuser/tlast).
// master drives the stream, slave only observes it.
interface axis_reshaper_ctl_if;

    logic snoop_tvalid;
    logic snoop_tready;
    logic snoop_tuser;
    logic snoop_tlast;

    modport master (output snoop_tvalid, output snoop_tready, output snoop_tuser, output snoop_tlast);
    modport slave  (input  snoop_tvalid, input  snoop_tready, input  snoop_tuser, input  snoop_tlast);

endinterface

// File: rtl/axis_frame_monitor.sv
// Decodes SOF/EOL from the snooped handshake, counts lines per frame and
// produces frame_good (at SOF) and overrun (at EOL) strobes for the controller.
module axis_frame_monitor
    import axis_reshaper_pkg::*;
#(
    parameter int C_HEIGHT_BITS = 12
) (
    input  logic                     clk,
    input  logic                     resetn,
    axis_reshaper_ctl_if.slave       snoop,
    input  logic                     rs_resetn,
    input  logic [C_HEIGHT_BITS-1:0] m_height,
    output logic                     sof,
    output logic                     frame_good,
    output logic                     overrun
);

    localparam logic [C_HEIGHT_BITS-1:0] LINE_ONE = {{(C_HEIGHT_BITS-1){1'b0}}, 1'b1};

    logic                     beat_s;
    logic                     eol_s;
    logic [C_HEIGHT_BITS-1:0] line_cnt_r;
    logic                     rs_low_r;

    assign beat_s     = snoop.snoop_tvalid & snoop.snoop_tready;
    assign sof        = beat_s & snoop.snoop_tuser;
    assign eol_s      = beat_s & snoop.snoop_tlast;
    // The SOF beat closes the previous frame, so it is judged on the old count.
    assign frame_good = sof & (line_cnt_r == m_height) & ~rs_low_r;
    assign overrun    = eol_s & ~sof & (line_cnt_r >= m_height);

    // Line counter and sticky "reshaper dropped since last SOF" flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            line_cnt_r <= '0;
            rs_low_r   <= 1'b0;
        end else begin
            if (sof) begin
                line_cnt_r <= snoop.snoop_tlast ? LINE_ONE : '0;
            end else if (eol_s && (line_cnt_r != '1)) begin
                line_cnt_r <= line_cnt_r + LINE_ONE;
            end else begin
                line_cnt_r <= line_cnt_r;
            end
            if (sof) begin
                rs_low_r <= ~rs_resetn;
            end else begin
                rs_low_r <= rs_low_r | ~rs_resetn;
            end
        end
    end

endmodule

// File: rtl/axis_reshaper_ctl.sv
// Sequencing controller for the AXI-Stream reshaper: frame-aligned geometry
// updates, frame-integrity lock FSM, downstream gating and fault/frame counters.
module axis_reshaper_ctl
    import axis_reshaper_pkg::*;
#(
    parameter int C_WIDTH_BITS  = 12,
    parameter int C_HEIGHT_BITS = 12,
    parameter int C_LOCK_FRAMES = 2,
    parameter int C_DEF_WIDTH   = 640,
    parameter int C_DEF_HEIGHT  = 480,
    parameter int C_CNT_BITS    = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [C_WIDTH_BITS-1:0]  cfg_width,
    input  logic [C_HEIGHT_BITS-1:0] cfg_height,
    input  logic                     cfg_update,
    output logic                     cfg_pending,
    output logic                     cfg_reject,
    axis_reshaper_ctl_if.slave       snoop,
    input  logic                     rs_resetn,
    output logic [C_WIDTH_BITS-1:0]  m_width,
    output logic [C_HEIGHT_BITS-1:0] m_height,
    output logic                     out_enable,
    output logic                     locked,
    output logic [C_CNT_BITS-1:0]    err_count,
    output logic [C_CNT_BITS-1:0]    frame_count
);

    localparam int                 GC_BITS  = $clog2(C_LOCK_FRAMES + 1);
    localparam logic [GC_BITS-1:0] GC_ONE   = GC_BITS'(1);
    localparam logic [GC_BITS-1:0] LOCK_TGT = GC_BITS'(C_LOCK_FRAMES);
    localparam logic [C_CNT_BITS-1:0] CNT_ONE = C_CNT_BITS'(1);

    logic                     sof_s;
    logic                     frame_good_s;
    logic                     overrun_s;
    logic                     apply_s;
    logic                     cfg_ok_s;
    logic                     fault_s;

    state_t                   state_r;
    logic [GC_BITS-1:0]       good_cnt_r;
    logic                     locked_r;
    logic [C_WIDTH_BITS-1:0]  m_width_r;
    logic [C_HEIGHT_BITS-1:0] m_height_r;
    logic [C_WIDTH_BITS-1:0]  shadow_w_r;
    logic [C_HEIGHT_BITS-1:0] shadow_h_r;
    logic                     pending_r;
    logic                     reject_r;
    logic [C_CNT_BITS-1:0]    err_cnt_r;
    logic [C_CNT_BITS-1:0]    frame_cnt_r;

    axis_frame_monitor #(
        .C_HEIGHT_BITS (C_HEIGHT_BITS)
    ) u_monitor (
        .clk        (clk),
        .resetn     (resetn),
        .snoop      (snoop),
        .rs_resetn  (rs_resetn),
        .m_height   (m_height_r),
        .sof        (sof_s),
        .frame_good (frame_good_s),
        .overrun    (overrun_s)
    );

    assign cfg_ok_s = geom_ok(32'(cfg_width), 32'(cfg_height));
    assign apply_s  = sof_s & pending_r;
    // WAIT_SOF has no frame reference yet, so nothing there is a fault.
    assign fault_s  = (state_r != WAIT_SOF) & (~rs_resetn | overrun_s | (sof_s & ~frame_good_s));

    // Shadow geometry, pending/reject flags and frame-aligned apply
    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_width_r  <= C_WIDTH_BITS'(C_DEF_WIDTH);
            m_height_r <= C_HEIGHT_BITS'(C_DEF_HEIGHT);
            shadow_w_r <= C_WIDTH_BITS'(C_DEF_WIDTH);
            shadow_h_r <= C_HEIGHT_BITS'(C_DEF_HEIGHT);
            pending_r  <= 1'b0;
            reject_r   <= 1'b0;
        end else begin
            if (apply_s) begin
                m_width_r  <= shadow_w_r;
                m_height_r <= shadow_h_r;
            end else begin
                m_width_r  <= m_width_r;
                m_height_r <= m_height_r;
            end
            // A request on the SOF cycle is only latched; the older shadow applies now.
            if (cfg_update && cfg_ok_s) begin
                shadow_w_r <= cfg_width;
                shadow_h_r <= cfg_height;
                pending_r  <= 1'b1;
            end else if (apply_s) begin
                pending_r  <= 1'b0;
            end else begin
                pending_r  <= pending_r;
            end
            reject_r <= cfg_update & ~cfg_ok_s;
        end
    end

    // Lock FSM with registered lock output
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= WAIT_SOF;
            good_cnt_r <= '0;
            locked_r   <= 1'b0;
        end else if ((state_r != WAIT_SOF) && (!rs_resetn || overrun_s)) begin
            state_r    <= WAIT_SOF;
            good_cnt_r <= '0;
            locked_r   <= 1'b0;
        end else if (sof_s) begin
            case (state_r)
                WAIT_SOF: begin
                    state_r    <= LOCKING;
                    good_cnt_r <= '0;
                    locked_r   <= 1'b0;
                end
                LOCKING: begin
                    if (apply_s || !frame_good_s) begin
                        state_r    <= LOCKING;
                        good_cnt_r <= '0;
                        locked_r   <= 1'b0;
                    end else if ((good_cnt_r + GC_ONE) == LOCK_TGT) begin
                        state_r    <= LOCKED;
                        good_cnt_r <= LOCK_TGT;
                        locked_r   <= 1'b1;
                    end else begin
                        state_r    <= LOCKING;
                        good_cnt_r <= good_cnt_r + GC_ONE;
                        locked_r   <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (apply_s || !frame_good_s) begin
                        state_r    <= LOCKING;
                        good_cnt_r <= '0;
                        locked_r   <= 1'b0;
                    end else begin
                        state_r    <= LOCKED;
                        good_cnt_r <= good_cnt_r;
                        locked_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= WAIT_SOF;
                    good_cnt_r <= '0;
                    locked_r   <= 1'b0;
                end
            endcase
        end else begin
            state_r    <= state_r;
            good_cnt_r <= good_cnt_r;
            locked_r   <= (state_r == LOCKED);
        end
    end

    // Saturating fault counter and wrapping SOF counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_cnt_r   <= '0;
            frame_cnt_r <= '0;
        end else begin
            if (fault_s && (err_cnt_r != '1)) begin
                err_cnt_r <= err_cnt_r + CNT_ONE;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
            if (sof_s) begin
                frame_cnt_r <= frame_cnt_r + CNT_ONE;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign m_width     = m_width_r;
    assign m_height    = m_height_r;
    assign cfg_pending = pending_r;
    assign cfg_reject  = reject_r;
    assign locked      = locked_r;
    assign out_enable  = locked_r & rs_resetn;
    assign err_count   = err_cnt_r;
    assign frame_count = frame_cnt_r;

endmodule

// File: tb/tb_axis_reshaper_ctl.sv
// Randomized and directed bench for axis_reshaper_ctl, checked every cycle
// against a frame-level reference model.
module tb_axis_reshaper_ctl;

    localparam int WB  = 12;
    localparam int HB  = 12;
    localparam int NL  = 2;
    localparam int CB  = 4;
    localparam int CMX = 15;

    logic          clk = 1'b0;
    logic          resetn;
    logic [WB-1:0] cfg_width;
    logic [HB-1:0] cfg_height;
    logic          cfg_update;
    logic          cfg_pending;
    logic          cfg_reject;
    logic          rs_resetn;
    logic [WB-1:0] m_width;
    logic [HB-1:0] m_height;
    logic          out_enable;
    logic          locked;
    logic [CB-1:0] err_count;
    logic [CB-1:0] frame_count;

    axis_reshaper_ctl_if snoop ();

    axis_reshaper_ctl #(
        .C_WIDTH_BITS  (WB),
        .C_HEIGHT_BITS (HB),
        .C_LOCK_FRAMES (NL),
        .C_DEF_WIDTH   (640),
        .C_DEF_HEIGHT  (480),
        .C_CNT_BITS    (CB)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .cfg_update  (cfg_update),
        .cfg_pending (cfg_pending),
        .cfg_reject  (cfg_reject),
        .snoop       (snoop),
        .rs_resetn   (rs_resetn),
        .m_width     (m_width),
        .m_height    (m_height),
        .out_enable  (out_enable),
        .locked      (locked),
        .err_count   (err_count),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: geometry, lock progress as a run of good frames, line tally.
    int md_w, md_h, sh_w, sh_h, lines, run_len, errs, frames;
    bit pend, exp_rej, synced, dropped;
    bit noise = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        md_w = 640; md_h = 480; sh_w = 640; sh_h = 480;
        pend = 1'b0; exp_rej = 1'b0; synced = 1'b0; dropped = 1'b0;
        lines = 0; run_len = 0; errs = 0; frames = 0;
    endtask

    task automatic model_update();
        bit beat, sof, eol, bad, ovr, apply, ok, fault;
        if (!resetn) begin
            model_reset();
            return;
        end
        beat  = snoop.snoop_tvalid && snoop.snoop_tready;
        sof   = beat && snoop.snoop_tuser;
        eol   = beat && snoop.snoop_tlast && !sof;
        bad   = (lines != md_h) || dropped;
        ovr   = eol && (lines + 1 > md_h);
        apply = sof && pend;
        ok    = (cfg_width >= 2) && (cfg_height >= 1);
        fault = synced && (!rs_resetn || ovr || (sof && bad));
        if (synced && (!rs_resetn || ovr)) begin
            synced = 1'b0; run_len = 0;
        end else if (sof) begin
            if (!synced) begin
                synced = 1'b1; run_len = 0;
            end else if (apply || bad) begin
                run_len = 0;
            end else if (run_len < NL) begin
                run_len++;
            end
        end
        if (apply) begin md_w = sh_w; md_h = sh_h; end
        exp_rej = cfg_update && !ok;
        if (cfg_update && ok) begin
            sh_w = int'(cfg_width); sh_h = int'(cfg_height); pend = 1'b1;
        end else if (apply) begin
            pend = 1'b0;
        end
        if (sof) begin
            lines = snoop.snoop_tlast ? 1 : 0;
            dropped = !rs_resetn;
        end else begin
            if (eol) lines++;
            if (!rs_resetn) dropped = 1'b1;
        end
        if (fault && errs < CMX) errs++;
        if (sof) frames = (frames + 1) % (CMX + 1);
    endtask

    task automatic step();
        bit exp_lock;
        model_update();
        @(posedge clk);
        #1;
        exp_lock = synced && (run_len >= NL);
        check("m_width", m_width, md_w);
        check("m_height", m_height, md_h);
        check("cfg_pending", cfg_pending, pend);
        check("cfg_reject", cfg_reject, exp_rej);
        check("locked", locked, exp_lock);
        check("out_enable", out_enable, exp_lock && rs_resetn);
        check("err_count", err_count, errs);
        check("frame_count", frame_count, frames);
        cfg_update = 1'b0;
    endtask

    task automatic idle_noise();
        snoop.snoop_tvalid = 1'($urandom_range(0, 1));
        snoop.snoop_tready = snoop.snoop_tvalid ? 1'b0 : 1'($urandom_range(0, 1));
        snoop.snoop_tuser  = 1'($urandom_range(0, 1));
        snoop.snoop_tlast  = 1'($urandom_range(0, 1));
        step();
        snoop.snoop_tvalid = 1'b0; snoop.snoop_tready = 1'b0;
        snoop.snoop_tuser  = 1'b0; snoop.snoop_tlast  = 1'b0;
    endtask

    task automatic beat(input bit user, input bit last);
        if (noise) begin
            while ($urandom_range(0, 3) == 0) idle_noise();
            rs_resetn = ($urandom_range(0, 80) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 40) == 0) begin
                cfg_update = 1'b1;
                cfg_width  = WB'($urandom_range(0, 5));
                cfg_height = HB'($urandom_range(0, 4));
            end
        end
        snoop.snoop_tvalid = 1'b1; snoop.snoop_tready = 1'b1;
        snoop.snoop_tuser  = user; snoop.snoop_tlast  = last;
        step();
        snoop.snoop_tvalid = 1'b0; snoop.snoop_tready = 1'b0;
        snoop.snoop_tuser  = 1'b0; snoop.snoop_tlast  = 1'b0;
        rs_resetn = 1'b1;
    endtask

    task automatic send_lines(input int w, input int n, input bit with_sof);
        for (int l = 0; l < n; l++)
            for (int p = 0; p < w; p++)
                beat(with_sof && (l == 0) && (p == 0), p == w - 1);
    endtask

    task automatic send_frame(input int w, input int n);
        send_lines(w, n, 1'b1);
    endtask

    task automatic cfg_req(input int w, input int h);
        cfg_update = 1'b1;
        cfg_width  = WB'(w);
        cfg_height = HB'(h);
        step();
    endtask

    initial begin
        resetn = 1'b0; rs_resetn = 1'b1; cfg_update = 1'b0;
        cfg_width = '0; cfg_height = '0;
        snoop.snoop_tvalid = 1'b0; snoop.snoop_tready = 1'b0;
        snoop.snoop_tuser  = 1'b0; snoop.snoop_tlast  = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        step();
        check("reset_m_width", m_width, 640);
        check("reset_m_height", m_height, 480);

        // Three clean 4x3 frames, geometry requested before the first SOF
        cfg_req(4, 3);
        check("t1_pending", cfg_pending, 1);
        send_frame(4, 3);
        send_frame(4, 3);
        check("t1_not_yet_locked", locked, 0);
        send_frame(4, 3);
        check("t1_locked", locked, 1);
        check("t1_out_enable", out_enable, 1);
        check("t1_err", err_count, 0);
        check("t1_frames", frame_count, 3);

        // Mid-frame update to 8x2 while locked
        send_lines(4, 1, 1'b1);
        cfg_req(8, 2);
        check("t2_pending", cfg_pending, 1);
        send_lines(4, 2, 1'b0);
        beat(1'b1, 1'b0);
        check("t2_m_width", m_width, 8);
        check("t2_m_height", m_height, 2);
        check("t2_unlocked", locked, 0);
        check("t2_pending_clr", cfg_pending, 0);
        for (int p = 1; p < 8; p++) beat(1'b0, p == 7);
        send_lines(8, 1, 1'b0);
        send_frame(8, 2);
        check("t2_relock_wait", locked, 0);
        send_frame(8, 2);
        check("t2_relocked", locked, 1);

        // Invalid width is refused
        cfg_req(1, 5);
        check("t3_reject", cfg_reject, 1);
        check("t3_width_kept", m_width, 8);
        check("t3_no_pending", cfg_pending, 0);
        step();
        check("t3_reject_pulse", cfg_reject, 0);

        // Short frame while locked on 4x3
        cfg_req(4, 3);
        send_frame(4, 3);
        send_frame(4, 3);
        send_frame(4, 3);
        check("t4_locked", locked, 1);
        send_lines(4, 2, 1'b1);
        beat(1'b1, 1'b0);
        check("t4_err", err_count, 1);
        check("t4_unlocked", locked, 0);
        check("t4_out_enable", out_enable, 0);
        for (int p = 1; p < 4; p++) beat(1'b0, p == 3);
        send_lines(4, 2, 1'b0);
        send_frame(4, 3);
        send_frame(4, 3);
        check("t4_relocked", locked, 1);

        // Reshaper reset pulse while locked
        rs_resetn = 1'b0;
        #1;
        check("t5_gate_same_cycle", out_enable, 0);
        step();
        rs_resetn = 1'b1;
        check("t5_unlocked", locked, 0);
        check("t5_err", err_count, 2);
        send_frame(4, 3);
        send_frame(4, 3);
        check("t5_relock_wait", locked, 0);
        send_frame(4, 3);
        check("t5_relocked", locked, 1);

        // Drive the fault counter into saturation; frame counter wraps
        for (int i = 0; i < 17; i++) begin
            beat(1'b1, 1'b0);
            rs_resetn = 1'b0;
            step();
            rs_resetn = 1'b1;
        end
        check("t6_err_sat", err_count, 15);

        // Randomized frames with noise, resets and config traffic
        noise = 1'b1;
        for (int f = 0; f < 60; f++) begin
            int n;
            n = md_h + $urandom_range(0, 2) - 1;
            if (n < 1) n = 1;
            if (n > 6) n = 6;
            send_frame($urandom_range(2, 5), n);
        end
        noise = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
